adder_byte_serializer: RTL and testbench
========================================

Name: adder_byte_serializer

Overview:
- Upstream stage of the USB bridge's SERIAL path.
- Buffers 64-bit adder result words in a small FIFO and unpacks each word into bytes, least-significant byte first.
- Presents one byte at a time with a ready flag, matching the bridge's per-channel byte input and ready_for_transmit pair.
- One instance per channel (1..4). Runs entirely in the clk domain.

Parameters:
- DEPTH_LOG2, 2, log2 of FIFO depth in 64-bit words (default 4 words).
- LSB_FIRST, 1, byte order. 1: byte0 = data[7:0] first. 0: data[63:56] first.

Ports:
- clk  input  1  system clock; all logic on its rising edge.
- rst  input  1  asynchronous, active-low reset (0 = reset).
- clear  input  1  synchronous flush: empties the FIFO, returns the FSM to IDLE, clears the sticky flags.
- adder_data_in  input  64  result word from the adder.
- adder_valid  input  1  word present. Accepted on a cycle with adder_valid=1 and adder_ready=1.
- adder_ready  output  1  FIFO not full (registered).
- byte_rd  input  1  consumer pop strobe, one byte per high cycle.
- tx_byte  output  8  current byte (registered).
- tx_ready  output  1  tx_byte is valid; feeds the bridge's adder_data_ready_for_transmit.
- word_count  output  DEPTH_LOG2+1  words held in the FIFO, excluding the word in the shift register.
- overflow  output  1  sticky: a write was attempted while full.
- underflow  output  1  sticky: byte_rd was seen while tx_ready=0.

Behaviour:
- Reset (rst=0, asynchronous) values:
  - adder_ready=1, tx_ready=0, tx_byte=8'h00, word_count=0, overflow=0, underflow=0.
  - FIFO pointers 0; FSM in IDLE; byte index 0.
- FIFO:
  - Circular buffer of 2^DEPTH_LOG2 words, with read and write pointers one bit wider than the address.
  - full when the addresses are equal and the MSBs differ; empty when the pointers are equal.
  - Pointers wrap modulo 2^(DEPTH_LOG2+1).
  - Write while full: word dropped, overflow<=1, pointers unchanged.
- FSM states:
  - IDLE: tx_ready=0. If the FIFO is not empty, go to LOAD.
  - LOAD (1 cycle): pop the FIFO head into the 64-bit shift register, byte index<=0. Next state SEND, with tx_ready<=1 and tx_byte<=first byte.
  - SEND: tx_ready=1. On byte_rd=1, advance the byte index and drive the next byte on the following cycle.
    - After the byte at index 7 is popped: go to LOAD if the FIFO is non-empty, else IDLE. tx_ready drops for the LOAD/IDLE cycle.
    - If byte_rd=0, hold tx_byte and tx_ready.
- Latency: a word accepted at edge N gives tx_ready=1 with byte0 at edge N+2 when the FSM was idle (FIFO write at N, LOAD at N+1).
- Throughput:
  - 8 bytes per word, with one bubble cycle between words.
  - Back-to-back byte_rd in SEND pops one byte per clk.
- Simultaneous events:
  - Write and LOAD pop in the same cycle: both occur and word_count is unchanged. A write while full is still rejected, even if a pop happens that cycle.
  - adder_ready is registered from the next-cycle count, so it is accurate in the same cycle as the pop.
  - byte_rd in IDLE/LOAD: ignored, underflow<=1.
- clear:
  - Priority over all other activity in that cycle, including an incoming write, which is dropped without setting overflow.
  - Outputs take their reset values on the next edge.
- Reset mid-operation: the partially sent word is discarded; no bytes are emitted after reset deasserts until a new word arrives.
- Byte order:
  - LSB_FIRST=1: index k outputs data[8k+7:8k].
  - LSB_FIRST=0: index k outputs data[63-8k:56-8k].

Optional Feature:
- Macro ADDER_SER_HEADER_EN.
- Defined:
  - Each word is framed as 10 bytes: 8'hA5, then the 8 data bytes, then an 8-bit XOR checksum of the 8 data bytes.
  - The byte index runs 0..9; LOAD outputs 8'hA5 first.
  - The checksum is computed at LOAD and held in a register.
- Not defined: 8 raw data bytes per word as above; no header or checksum logic is synthesised.

Test Plan:
- Single word: after reset, write 64'h0807060504030201, pulse byte_rd each cycle while tx_ready=1 -> tx_byte sequence 01,02,...,08; tx_ready=1 at edge N+2; tx_ready=0 after the 8th pop; word_count 1->0.
- LSB_FIRST=0 with the same word -> sequence 08,07,...,01.
- Fill FIFO: with DEPTH_LOG2=2 and byte_rd held 0, write 6 words -> word 1 moves to the shift register, words 2-5 fill the FIFO, word_count=4, adder_ready=0, overflow=1; words 1-5 drain intact in order, the 6th is absent.
- Underflow: pulse byte_rd in IDLE -> underflow=1, tx_byte unchanged. clear pulse -> underflow=0, overflow=0, word_count=0, tx_ready=0.
- Mid-word reset: pop 3 of 8 bytes, assert rst=0 for 1 cycle -> tx_ready=0 immediately (asynchronous), word_count=0; next word 64'hFFEEDDCCBBAA9988 sends 88 first.
- ADDER_SER_HEADER_EN: word 64'h0807060504030201 -> A5,01,...,08,08 (XOR of 01..08 = 08), 10 pops; the next word starts with A5.

Source files
------------

// File: rtl/adder_byte_serializer_if.sv
// Handshake and status bundle for adder_byte_serializer: the adder word input side,
// the per-channel byte output/ready pair, and the FIFO status flags.
interface adder_byte_serializer_if #(
  parameter int unsigned DEPTH_LOG2 = 2
);
  logic [63:0]         adder_data_in;
  logic                adder_valid;
  logic                adder_ready;
  logic                byte_rd;
  logic [7:0]          tx_byte;
  logic                tx_ready;
  logic [DEPTH_LOG2:0] word_count;
  logic                overflow;
  logic                underflow;

  modport master (
    output adder_data_in, adder_valid, byte_rd,
    input  adder_ready, tx_byte, tx_ready, word_count, overflow, underflow
  );

  modport slave (
    input  adder_data_in, adder_valid, byte_rd,
    output adder_ready, tx_byte, tx_ready, word_count, overflow, underflow
  );
endinterface

// File: rtl/adder_byte_serializer.sv
// Buffers 64-bit adder words in a small FIFO and presents them one byte at a time.
// Define ADDER_SER_HEADER_EN to frame each word as A5, 8 data bytes, XOR checksum.
module adder_byte_serializer #(
  parameter int unsigned DEPTH_LOG2 = 2,
  parameter bit          LSB_FIRST  = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  adder_byte_serializer_if.slave bus
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
`ifdef ADDER_SER_HEADER_EN
  localparam logic [3:0] LAST_IDX = 4'd9;
`else
  localparam logic [3:0] LAST_IDX = 4'd7;
`endif

  typedef logic [DEPTH_LOG2:0] ptr_t;
  typedef enum logic [1:0] {IDLE, LOAD, SEND} state_t;

  state_t      state;
  logic [63:0] mem [DEPTH];
  ptr_t        wr_ptr, rd_ptr, count_next;
  logic        full, empty, push, pop;
  logic [63:0] head, shreg;
  logic [3:0]  idx;
  logic [7:0]  first_byte, next_byte;

  function automatic logic [7:0] data_byte(input logic [63:0] w, input logic [2:0] j);
    if (LSB_FIRST) return w[{j, 3'b000} +: 8];
    else           return w[{~j, 3'b000} +: 8];
  endfunction

  assign empty      = (wr_ptr == rd_ptr);
  assign full       = (wr_ptr[DEPTH_LOG2-1:0] == rd_ptr[DEPTH_LOG2-1:0]) &&
                      (wr_ptr[DEPTH_LOG2] != rd_ptr[DEPTH_LOG2]);
  assign push       = bus.adder_valid && !full && !clear;
  assign pop        = (state == LOAD) && !clear;
  assign head       = mem[rd_ptr[DEPTH_LOG2-1:0]];
  assign count_next = wr_ptr - rd_ptr + ptr_t'(push) - ptr_t'(pop);
  assign bus.word_count = wr_ptr - rd_ptr;

`ifdef ADDER_SER_HEADER_EN
  logic [7:0] csum, head_csum;

  always_comb begin
    head_csum = '0;
    for (int unsigned i = 0; i < 8; i++) head_csum ^= head[8*i +: 8];
  end

  // idx counts frame bytes; data byte k sits at frame index k+1
  assign first_byte = 8'hA5;
  assign next_byte  = (idx == LAST_IDX - 4'd1) ? csum : data_byte(shreg, 3'(idx));
`else
  assign first_byte = data_byte(head, 3'd0);
  assign next_byte  = data_byte(shreg, 3'(idx + 4'd1));
`endif

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[DEPTH_LOG2-1:0]] <= bus.adder_data_in;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr          <= '0;
      rd_ptr          <= '0;
      bus.adder_ready <= 1'b1;
      bus.overflow    <= 1'b0;
    end else if (clear) begin
      wr_ptr          <= '0;
      rd_ptr          <= '0;
      bus.adder_ready <= 1'b1;
      bus.overflow    <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + ptr_t'(1);
      if (pop)  rd_ptr <= rd_ptr + ptr_t'(1);
      if (bus.adder_valid && full) bus.overflow <= 1'b1;
      bus.adder_ready <= (count_next != ptr_t'(DEPTH));
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= IDLE;
      shreg         <= '0;
      idx           <= '0;
      bus.tx_byte   <= '0;
      bus.tx_ready  <= 1'b0;
      bus.underflow <= 1'b0;
`ifdef ADDER_SER_HEADER_EN
      csum          <= '0;
`endif
    end else if (clear) begin
      state         <= IDLE;
      idx           <= '0;
      bus.tx_byte   <= '0;
      bus.tx_ready  <= 1'b0;
      bus.underflow <= 1'b0;
    end else begin
      if (bus.byte_rd && state != SEND) bus.underflow <= 1'b1;
      unique case (state)
        IDLE: if (!empty) state <= LOAD;
        LOAD: begin
          shreg        <= head;
          idx          <= '0;
          bus.tx_byte  <= first_byte;
          bus.tx_ready <= 1'b1;
`ifdef ADDER_SER_HEADER_EN
          csum         <= head_csum;
`endif
          state        <= SEND;
        end
        SEND: if (bus.byte_rd) begin
          if (idx == LAST_IDX) begin
            bus.tx_ready <= 1'b0;
            state        <= empty ? IDLE : LOAD;
          end else begin
            idx         <= idx + 4'd1;
            bus.tx_byte <= next_byte;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_adder_byte_serializer.sv
// Self-checking bench: two serializers (LSB-first and MSB-first) on shared stimulus,
// checked every cycle against a queue-based model plus directed corner-case sequences.
module tb_adder_byte_serializer;

  localparam int unsigned DL    = 2;
  localparam int unsigned DEPTH = 4;
`ifdef ADDER_SER_HEADER_EN
  localparam int unsigned FLEN = 10;
  localparam int unsigned HDR  = 1;
`else
  localparam int unsigned FLEN = 8;
  localparam int unsigned HDR  = 0;
`endif

  logic        clk = 1'b0;
  logic        rst_n, clear, valid, rd;
  logic [63:0] data;

  always #5 clk = ~clk;

  adder_byte_serializer_if #(.DEPTH_LOG2(DL)) bus_l ();
  adder_byte_serializer_if #(.DEPTH_LOG2(DL)) bus_m ();

  assign bus_l.adder_data_in = data;
  assign bus_l.adder_valid   = valid;
  assign bus_l.byte_rd       = rd;
  assign bus_m.adder_data_in = data;
  assign bus_m.adder_valid   = valid;
  assign bus_m.byte_rd       = rd;

  adder_byte_serializer #(.DEPTH_LOG2(DL), .LSB_FIRST(1'b1)) dut_l (
    .clk(clk), .rst(rst_n), .clear(clear), .bus(bus_l));
  adder_byte_serializer #(.DEPTH_LOG2(DL), .LSB_FIRST(1'b0)) dut_m (
    .clk(clk), .rst(rst_n), .clear(clear), .bus(bus_m));

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: FIFO of words, queues of bytes still to be presented
  logic [63:0] mq[$];
  logic [7:0]  cl[$], cm[$];
  bit          pend, m_ovf, m_und;
  logic [7:0]  last_l, last_m;

  task automatic model_reset();
    mq.delete(); cl.delete(); cm.delete();
    pend = 0; m_ovf = 0; m_und = 0; last_l = '0; last_m = '0;
  endtask

  task automatic model_frame(input logic [63:0] w);
    logic [7:0] x, bl, bm;
    x = '0;
    if (HDR != 0) begin cl.push_back(8'hA5); cm.push_back(8'hA5); end
    for (int k = 0; k < 8; k++) begin
      bl = 8'((w >> (8*k)) & 64'hFF);
      bm = 8'((w >> (8*(7-k))) & 64'hFF);
      cl.push_back(bl); cm.push_back(bm);
      x ^= bl;
    end
    if (HDR != 0) begin cl.push_back(x); cm.push_back(x); end
  endtask

  task automatic model_step();
    bit full_now, ne;
    if (clear) begin model_reset(); return; end
    full_now = (mq.size() == DEPTH);
    ne       = (mq.size() != 0);
    if (rd && cl.size() == 0) m_und = 1;
    if (pend) begin
      model_frame(mq.pop_front());
      pend = 0;
    end else if (cl.size() != 0) begin
      if (rd) begin
        void'(cl.pop_front()); void'(cm.pop_front());
        if (cl.size() == 0) pend = ne;
      end
    end else if (ne) pend = 1;
    if (valid) begin
      if (full_now) m_ovf = 1;
      else mq.push_back(data);
    end
    if (cl.size() != 0) begin last_l = cl[0]; last_m = cm[0]; end
  endtask

  always @(negedge clk) begin
    if (!rst_n) model_reset();
    check("tx_ready_l",    bus_l.tx_ready,    64'(cl.size() != 0));
    check("tx_ready_m",    bus_m.tx_ready,    64'(cl.size() != 0));
    check("tx_byte_l",     bus_l.tx_byte,     last_l);
    check("tx_byte_m",     bus_m.tx_byte,     last_m);
    check("word_count_l",  bus_l.word_count,  64'(mq.size()));
    check("word_count_m",  bus_m.word_count,  64'(mq.size()));
    check("adder_ready_l", bus_l.adder_ready, 64'(mq.size() < DEPTH));
    check("adder_ready_m", bus_m.adder_ready, 64'(mq.size() < DEPTH));
    check("overflow_l",    bus_l.overflow,    m_ovf);
    check("underflow_l",   bus_l.underflow,   m_und);
    check("underflow_m",   bus_m.underflow,   m_und);
    if (rst_n) model_step();
  end

  task automatic tick();
    @(posedge clk); #2;
  endtask

  logic [7:0] got_l[FLEN], got_m[FLEN];

  task automatic wait_tx(input int budget);
    int n = 0;
    while (!bus_l.tx_ready && n < budget) begin tick(); n++; end
    check("wait_tx", bus_l.tx_ready, 1);
  endtask

  task automatic pop_frame();
    rd = 1;
    for (int unsigned i = 0; i < FLEN; i++) begin
      got_l[i] = bus_l.tx_byte;
      got_m[i] = bus_m.tx_byte;
      tick();
    end
    rd = 0;
  endtask

  task automatic send_word(input logic [63:0] w);
    data = w; valid = 1; tick(); valid = 0;
  endtask

  function automatic logic [63:0] recon();
    logic [63:0] w = '0;
    for (int unsigned k = 0; k < 8; k++) w |= 64'(got_l[HDR + k]) << (8*k);
    return w;
  endfunction

  function automatic logic [63:0] fw(input int unsigned i);
    return 64'h0123456789ABCDEF + 64'(i) * 64'h1111111111111111;
  endfunction

  function automatic logic [7:0] tail_l(input logic [63:0] w);
    logic [7:0] x = '0;
    for (int k = 0; k < 8; k++) x ^= 8'(w >> (8*k));
    return (HDR != 0) ? x : 8'(w >> 56);
  endfunction

  typedef struct {
    logic [63:0] word;
    logic [7:0]  first_l;
    logic [7:0]  first_m;
    logic [7:0]  xsum;
  } vec_t;

  vec_t       tbl[5];
  logic [7:0] exp_l[FLEN], exp_m[FLEN];
  logic [7:0] x;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{64'h0807060504030201, 8'h01, 8'h08, 8'h08};
    tbl[1] = '{64'hFFEEDDCCBBAA9988, 8'h88, 8'hFF, 8'h00};
    tbl[2] = '{64'h0000000000000000, 8'h00, 8'h00, 8'h00};
    tbl[3] = '{64'h00000000000000FF, 8'hFF, 8'h00, 8'hFF};
    tbl[4] = '{64'h8000000000000001, 8'h01, 8'h80, 8'h81};
`ifdef ADDER_SER_HEADER_EN
    exp_l = '{8'hA5, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h08};
    exp_m = '{8'hA5, 8'h08, 8'h07, 8'h06, 8'h05, 8'h04, 8'h03, 8'h02, 8'h01, 8'h08};
`else
    exp_l = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
    exp_m = '{8'h08, 8'h07, 8'h06, 8'h05, 8'h04, 8'h03, 8'h02, 8'h01};
`endif

    rst_n = 0; clear = 0; valid = 0; rd = 0; data = '0;
    repeat (2) @(posedge clk);
    #2 rst_n = 1;
    tick();

    // Single word: latency and byte order
    send_word(64'h0807060504030201);
    check("lat_wc_N", bus_l.word_count, 1);
    check("lat_txr_N", bus_l.tx_ready, 0);
    tick();
    check("lat_txr_N1", bus_l.tx_ready, 0);
    tick();
    check("lat_txr_N2", bus_l.tx_ready, 1);
    check("lat_wc_N2", bus_l.word_count, 0);
    for (int unsigned i = 0; i < FLEN; i++) begin
      check("seq_l", bus_l.tx_byte, exp_l[i]);
      check("seq_m", bus_m.tx_byte, exp_m[i]);
      rd = 1; tick(); rd = 0;
    end
    check("seq_done_txr", bus_l.tx_ready, 0);
    tick();

    // Table of words, consecutive pops
    for (int t = 0; t < 5; t++) begin
      send_word(tbl[t].word);
      wait_tx(5);
      pop_frame();
      check("tbl_first_l", got_l[HDR], tbl[t].first_l);
      check("tbl_first_m", got_m[HDR], tbl[t].first_m);
      x = '0;
      for (int unsigned k = 0; k < 8; k++) x ^= got_l[HDR + k];
      check("tbl_xor", x, tbl[t].xsum);
      if (HDR != 0) begin
        check("tbl_hdr", got_l[0], 8'hA5);
        check("tbl_csum", got_l[FLEN-1], tbl[t].xsum);
      end
      tick();
    end

    // Fill FIFO with no consumer; sixth word must be dropped
    for (int unsigned i = 1; i <= 6; i++) send_word(fw(i));
    check("fill_wc", bus_l.word_count, 4);
    check("fill_ready", bus_l.adder_ready, 0);
    check("fill_ovf", bus_l.overflow, 1);
    for (int unsigned i = 1; i <= 5; i++) begin
      wait_tx(4);
      pop_frame();
      check("drain_word", recon(), fw(i));
    end
    repeat (4) tick();
    check("drain_txr", bus_l.tx_ready, 0);
    check("drain_wc", bus_l.word_count, 0);

    // Underflow in IDLE, then clear racing a write
    rd = 1; tick(); rd = 0;
    check("und_flag", bus_l.underflow, 1);
    check("und_hold", bus_l.tx_byte, tail_l(fw(5)));
    clear = 1; data = 64'h5555AAAA5555AAAA; valid = 1; tick(); clear = 0; valid = 0;
    check("clr_und", bus_l.underflow, 0);
    check("clr_ovf", bus_l.overflow, 0);
    check("clr_wc", bus_l.word_count, 0);
    check("clr_txr", bus_l.tx_ready, 0);
    check("clr_byte", bus_l.tx_byte, 0);
    repeat (3) tick();
    check("clr_dropped", bus_l.tx_ready, 0);

    // Reset in the middle of a word
    send_word(64'h1122334455667788);
    wait_tx(5);
    rd = 1; repeat (3) tick(); rd = 0;
    check("mid_txr", bus_l.tx_ready, 1);
    rst_n = 0;
    #1;
    check("rst_async_txr_l", bus_l.tx_ready, 0);
    check("rst_async_txr_m", bus_m.tx_ready, 0);
    check("rst_async_wc", bus_l.word_count, 0);
    tick();
    rst_n = 1;
    repeat (3) tick();
    check("rst_quiet", bus_l.tx_ready, 0);
    send_word(64'hFFEEDDCCBBAA9988);
    wait_tx(5);
    check("rst_next_l", bus_l.tx_byte, (HDR != 0) ? 8'hA5 : 8'h88);
    check("rst_next_m", bus_m.tx_byte, (HDR != 0) ? 8'hA5 : 8'hFF);
    pop_frame();
    check("rst_next_word", recon(), 64'hFFEEDDCCBBAA9988);
    tick();

    // Random traffic: eager then lazy consumer
    for (int p = 0; p < 2; p++) begin
      for (int c = 0; c < 3000; c++) begin
        valid = ($urandom_range(0, 9) < 4);
        data  = {$urandom, $urandom};
        rd    = ($urandom_range(0, 9) < ((p == 0) ? 8 : 3));
        clear = ($urandom_range(0, 299) == 0);
        tick();
      end
      valid = 0; rd = 0; clear = 0;
      tick();
    end
    repeat (3) tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
